// File: rtl/watch_button_ctrl_pkg.sv
// Purpose: typed view of the shared stopwatch state encodings.
// Latency: n/a (types only).
// Backpressure: n/a.
`include "watch_defs.vh"

package watch_button_ctrl_pkg;

  localparam int STATE_W = `WATCH_STATE_W;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = `WATCH_IDLE,
    ST_RUN   = `WATCH_RUN,
    ST_PAUSE = `WATCH_PAUSE
  } state_e;

endpackage

// File: rtl/watch_button_ctrl_if.sv
// Purpose: bundles the raw buttons and the counter-facing level controls.
// Latency: n/a (wiring only).
// Backpressure: none; buttons and controls are plain levels.
// Ports: master drives btn_startstop/btn_clear and observes the controls;
//        slave (the controller) drives start_resume/stop/watch_reset/state.
interface watch_button_ctrl_if;
  import watch_button_ctrl_pkg::*;

  logic               btn_startstop;
  logic               btn_clear;
  logic               start_resume;
  logic               stop;
  logic               watch_reset;
  logic [STATE_W-1:0] state;

  modport master (
    output btn_startstop, btn_clear,
    input  start_resume, stop, watch_reset, state
  );

  modport slave (
    input  btn_startstop, btn_clear,
    output start_resume, stop, watch_reset, state
  );
endinterface

// File: rtl/watch_button_ctrl_button_debounce.sv
// Purpose: synchronise, debounce and edge-detect one raw push-button.
// Latency: press pulses DEBOUNCE_CYCLES+1 edges after the first high sample.
// Backpressure: none; press is a single-cycle pulse that must be consumed.
// Ports: clk, reset (sync, active-high), btn_raw (async),
//        level (debounced level), press (1-cycle rising-edge pulse).
`include "watch_defs.vh"

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] CNT_MAX  = '1;

  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                db_q, db_d;
  logic                db_dly_q, db_dly_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = btn_raw;
    s2_d     = s1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    cnt_d    = cnt_q;
    if (s2_q == db_q) begin
      // Any agreement with the accepted level restarts the qualification window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = db_q;
  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/watch_defs.vh
// Purpose: state encodings shared by the stopwatch control modules.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef WATCH_DEFS_VH
`define WATCH_DEFS_VH

`define WATCH_STATE_W 2
`define WATCH_IDLE    2'b00
`define WATCH_RUN     2'b01
`define WATCH_PAUSE   2'b10

`endif

// File: rtl/watch_button_ctrl.sv
// Purpose: turn start/stop and clear buttons into run/pause/idle counter controls.
// Latency: control change DEBOUNCE_CYCLES+2 edges after the first high button sample.
// Backpressure: none; outputs are registered-state levels, presses are never queued.
// Ports: clk, reset (sync, active-high), bus (slave modport of watch_button_ctrl_if).
`include "watch_defs.vh"

module watch_button_ctrl
  import watch_button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  watch_button_ctrl_if.slave   bus
);

  logic   ss_press, clr_press;
  // Debounced levels are not needed by the FSM; kept for a future display hookup.
  logic   unused_ss_level, unused_clr_level;
  state_e state_q, state_d;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_db_startstop (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_startstop),
    .level   (unused_ss_level),
    .press   (ss_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_db_clear (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_clear),
    .level   (unused_clr_level),
    .press   (clr_press)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_press) state_d = ST_RUN;
      ST_RUN:   if (ss_press) state_d = ST_PAUSE;
      ST_PAUSE: if (ss_press) state_d = ST_RUN;
      default:  state_d = ST_IDLE;  // illegal encoding recovers unconditionally
    endcase
    // Clear wins over a simultaneous start/stop press.
    if (clr_press) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    bus.start_resume = 1'b0;
    bus.stop         = 1'b0;
    bus.watch_reset  = 1'b0;
    bus.state        = state_q;
    case (state_q)
      ST_RUN:   bus.start_resume = 1'b1;
      ST_PAUSE: bus.stop         = 1'b1;
      default:  bus.watch_reset  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_watch_button_ctrl.sv
module tb_watch_button_ctrl;
  import watch_button_ctrl_pkg::*;

  typedef struct {
    int         due;
    logic [1:0] st;
  } exp_t;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  // Input driven after edge c is first sampled at edge c+1 (E0); the state
  // changes after E(DEBOUNCE_CYCLES+2) = c+1+6.
  localparam int LAT = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;

  watch_button_ctrl_if bif ();

  watch_button_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DB_CNT_W        (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         cyc    = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_st = S_IDLE;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, req);
    end
  endtask

  task automatic expect_at(input int delay, input logic [1:0] st);
    exp_t e;
    e.due = cyc + delay;
    e.st  = st;
    sb.push_back(e);
  endtask

  // One clock: retire scoreboard entries that fall due, then compare.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e      = sb.pop_front();
      exp_st = e.st;
    end
    chk("state",        bif.state,                  exp_st);
    chk("start_resume", {1'b0, bif.start_resume},   {1'b0, exp_st == S_RUN});
    chk("stop",         {1'b0, bif.stop},           {1'b0, exp_st == S_PAUSE});
    chk("watch_reset",  {1'b0, bif.watch_reset},    {1'b0, exp_st == S_IDLE});
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    bif.btn_startstop = 1'b0;
    bif.btn_clear     = 1'b0;

    // Reset for two edges, then idle with buttons low.
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(20);

    // Short glitches (3 cycles high, 1 low) never qualify.
    repeat (5) begin
      bif.btn_startstop = 1'b1;
      ticks(3);
      bif.btn_startstop = 1'b0;
      ticks(1);
    end
    ticks(10);

    // Held press: IDLE -> RUN once, no further change while held.
    bif.btn_startstop = 1'b1;
    expect_at(LAT, S_RUN);
    ticks(10);

    // Release, re-press -> PAUSE; third press -> RUN.
    bif.btn_startstop = 1'b0;
    ticks(8);
    bif.btn_startstop = 1'b1;
    expect_at(LAT, S_PAUSE);
    ticks(6);
    bif.btn_startstop = 1'b0;
    ticks(8);
    bif.btn_startstop = 1'b1;
    expect_at(LAT, S_RUN);
    ticks(6);
    bif.btn_startstop = 1'b0;
    ticks(8);

    // Simultaneous presses in RUN: clear wins.
    bif.btn_startstop = 1'b1;
    bif.btn_clear     = 1'b1;
    expect_at(LAT, S_IDLE);
    ticks(8);
    bif.btn_startstop = 1'b0;
    bif.btn_clear     = 1'b0;
    ticks(8);

    // Reach PAUSE with start/stop still held, then pulse reset.
    bif.btn_startstop = 1'b1;
    expect_at(LAT, S_RUN);
    ticks(6);
    bif.btn_startstop = 1'b0;
    ticks(8);
    bif.btn_startstop = 1'b1;
    expect_at(LAT, S_PAUSE);
    ticks(10);
    reset = 1'b1;
    expect_at(1, S_IDLE);
    expect_at(8, S_RUN);
    ticks(1);
    reset = 1'b0;
    ticks(12);
    bif.btn_startstop = 1'b0;
    ticks(4);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/watch_button_ctrl.md
Name: watch_button_ctrl

Overview:
Control stage directly upstream of the single-digit stopwatch counter. It turns two raw push-buttons (start/stop toggle, clear) into the counter's level controls: start_resume, stop and reset. It provides a two-flop synchroniser, a debouncer, rising-edge press detection and a 3-state run/pause/idle FSM.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a button level must hold before it is accepted (minimum 1).
DB_CNT_W, 8, width of each debounce counter; must satisfy 2^DB_CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  single system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high; clears all state on the next rising clk edge.
btn_startstop  input  1  raw asynchronous start/stop button, active-high.
btn_clear  input  1  raw asynchronous clear button, active-high.
start_resume  output  1  high while RUN; drives the counter's start_resume.
stop  output  1  high while PAUSE; drives the counter's stop.
watch_reset  output  1  high while IDLE; drives the counter's reset.
state  output  2  current FSM state, for debug and display.

Behaviour:
- Reset (clk edge with reset=1) sets:
  - sync flops = 0; debounced levels = 0; debounce counters = 0; previous-debounced regs = 0.
  - state = IDLE, so watch_reset=1, start_resume=0, stop=0.
- Synchroniser: 2 flops per button. s2 is the button value sampled two edges earlier.
- Debounce, per button, with registered level db:
  - s2==db: counter cleared to 0.
  - s2!=db and counter==DEBOUNCE_CYCLES-1: db<=s2, counter<=0.
  - otherwise: counter increments. It saturates and never wraps.
- Press pulse = db & ~db_q, where db_q is db delayed one cycle. The pulse is exactly 1 cycle wide, on rising edges only; releases generate nothing.
- FSM, encoded in the shared header: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; 2'b11 is illegal and recovers to IDLE on the next edge.
  - IDLE + ss_press -> RUN.
  - RUN + ss_press -> PAUSE.
  - PAUSE + ss_press -> RUN.
  - any state + clr_press -> IDLE.
  - clr_press and ss_press in the same cycle -> IDLE (clear has priority).
  - no press -> hold.
- Outputs are decoded from the registered state. Exactly one of start_resume/stop/watch_reset is high in every cycle after reset.
- Latency: let E0 be the first edge that samples the button high. With the button held, state and outputs change after edge E(DEBOUNCE_CYCLES+2). DEBOUNCE_CYCLES=4 gives E6.
- Glitch rejection: a synchronised pulse shorter than DEBOUNCE_CYCLES cycles is ignored. Any return to s2==db clears the counter.
- Button held high: produces a single press. A new press requires a debounced release and then a debounced re-press.
- Reset mid-operation:
  - state returns to IDLE and any in-progress debounce count is discarded.
  - a button still held when reset deasserts is re-debounced from db=0 and yields one press after DEBOUNCE_CYCLES+2 edges.
- No combinational path from the button inputs to any output.

Decomposition:
- Shared header watch_defs.vh, included by the watch modules: state encodings WATCH_IDLE, WATCH_RUN, WATCH_PAUSE, and the state width.
- One sub-module, button_debounce, instantiated twice:
  - parameters DEBOUNCE_CYCLES, DB_CNT_W.
  - ports clk, reset, btn_raw, level, press.
  - contents: synchroniser, counter, edge detect.
- The FSM and output decode live in watch_button_ctrl.

Test Plan:
1. reset=1 for 2 edges, then 0, buttons low -> state=00, watch_reset=1, start_resume=0, stop=0 held for 20 cycles.
2. btn_startstop high from E0 and held 10 cycles -> state=01, start_resume=1 after edge E6; no further change while held.
3. From RUN: release ss, wait 8 cycles, press again for 6 cycles -> PAUSE (stop=1). A third press -> RUN.
4. btn_startstop high for 3 cycles only (DEBOUNCE_CYCLES=4), repeated 5 times with 1-cycle gaps -> state stays 00 throughout.
5. In RUN, both buttons rise on the same edge and are held 8 cycles -> state=00, watch_reset=1 after E6, not PAUSE.
6. In PAUSE with btn_startstop held, pulse reset for 1 cycle:
   - the next edge gives IDLE.
   - the held button yields RUN exactly DEBOUNCE_CYCLES+2 edges after reset deasserts.
